// File: rtl/pc_gen.sv
// Program counter stage: boot cycle, next-PC select, stall, ebreak halt, retire count.
// Optional: PC_GEN_MISALIGN_EN halts on a misaligned taken target.
module pc_gen #(
  parameter logic [31:0] RESET_PC  = 32'h8000_0000,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 halt_req,
  input  logic [2:0]           branch,
  input  logic                 alu_zero,
  input  logic                 alu_less,
  input  logic [31:0]          imm,
  input  logic [31:0]          rs1_data,
  output logic [31:0]          pc,
  output logic [31:0]          pc_plus4,
  output logic                 pc_valid,
  output logic                 halted,
  output logic                 misalign,
  output logic [CNT_WIDTH-1:0] retire_cnt
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          pc_q, pc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 mis_q, mis_d;
  logic [31:0]          seq_tgt, br_tgt, jr_tgt, tgt;
  logic                 bad;

  assign seq_tgt = pc_q + 32'd4;
  assign br_tgt  = pc_q + imm;
  assign jr_tgt  = (rs1_data + imm) & ~32'h1;

  always_comb begin
    tgt = seq_tgt;
    unique case (1'b1)
      branch == 3'b001: tgt = br_tgt;
      branch == 3'b010: tgt = jr_tgt;
      branch == 3'b100: tgt = alu_zero ? br_tgt : seq_tgt;
      branch == 3'b101: tgt = alu_zero ? seq_tgt : br_tgt;
      branch == 3'b110: tgt = alu_less ? br_tgt : seq_tgt;
      branch == 3'b111: tgt = alu_less ? seq_tgt : br_tgt;
      default:          tgt = seq_tgt;
    endcase
  end

  // Sequential targets stay aligned, so only a taken target can trip this.
`ifdef PC_GEN_MISALIGN_EN
  assign bad = |tgt[1:0];
`else
  assign bad = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (!stall) begin
          if (halt_req) begin
            state_d = HALT;
            cnt_d   = cnt_q + CNT_WIDTH'(1);
          end else if (bad) begin
            state_d = HALT;
            mis_d   = 1'b1;
          end else begin
            pc_d  = tgt;
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      HALT: state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
    end
  end

  assign pc         = pc_q;
  assign pc_plus4   = seq_tgt;
  assign pc_valid   = (state_q == RUN);
  assign halted     = (state_q == HALT);
  assign misalign   = mis_q;
  assign retire_cnt = cnt_q;

endmodule
